// File: rtl/mc_controller.sv
// Multicycle control sequencer for the RV32I core: one datapath step per clock,
// stalls on the memory ready handshake, flags retirement and illegal encodings.
module mc_controller #(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       V,
  input  logic       N,
  input  logic       C,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       Retire,
  output logic       Illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_LUI, S_ILLEGAL
  } state_e;

  state_e state_q, state_d;

  logic pc_write_c, mem_write_c, ir_write_c, reg_write_c, retire_c;
  logic branch_taken_c;
  logic [3:0] alu_op_c;

  // ALU operation for register/immediate arithmetic; sub only for R-type funct3 000
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt,
                                            input logic is_reg);
    case (f3)
      3'b000:  return (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // State register, synchronous reset back to FETCH
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Immediate format follows the opcode in every state
  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      OP_LOAD, OP_IMM: ImmSrc = 3'b000;
      OP_STORE:        ImmSrc = 3'b001;
      OP_BRANCH:       ImmSrc = 3'b010;
      OP_JAL:          ImmSrc = 3'b011;
      OP_LUI:          ImmSrc = 3'b100;
      default:         ImmSrc = 3'b000;
    endcase
  end

  // Branch condition from the subtraction flags
  always_comb begin
    branch_taken_c = 1'b0;
    case (funct3)
      3'b000:  branch_taken_c = Zero;
      3'b001:  branch_taken_c = ~Zero;
      3'b100:  branch_taken_c = N ^ V;
      3'b101:  branch_taken_c = ~(N ^ V);
      3'b110:  branch_taken_c = ~C;
      3'b111:  branch_taken_c = C;
      default: branch_taken_c = 1'b0;
    endcase
  end

  assign alu_op_c = alu_decode(funct3, funct7b5, (state_q == S_EXECR));

  // Next-state and datapath control per state
  always_comb begin
    state_d     = state_q;
    pc_write_c  = 1'b0;
    AdrSrc      = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUControl  = ALU_ADD;
    retire_c    = 1'b0;
    Illegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        ir_write_c = MemReady;
        pc_write_c = MemReady;
        if (MemReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_REG:            state_d = S_EXECR;
          OP_IMM:            state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = S_LUI;
          OP_BRANCH:         state_d = (funct3[2:1] == 2'b01) ? S_ILLEGAL : S_BRANCH;
          default:           state_d = S_ILLEGAL;
        endcase
        // Skipped encodings retire here when halting is disabled
        if (state_d == S_ILLEGAL && !ILLEGAL_HALT) begin
          state_d  = S_FETCH;
          retire_c = 1'b1;
        end
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_c = 1'b1;
        if (MemReady) begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_op_c;
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_op_c;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        pc_write_c = branch_taken_c;
        retire_c   = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pc_write_c = 1'b1;
        state_d    = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
        state_d = S_ALUWB;
      end
      S_ILLEGAL: begin
        Illegal = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset suppresses every write enable and the retire pulse
  assign PCWrite  = pc_write_c  & ~reset;
  assign MemWrite = mem_write_c & ~reset;
  assign IRWrite  = ir_write_c  & ~reset;
  assign RegWrite = reg_write_c & ~reset;
  assign Retire   = retire_c    & ~reset;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: each cycle's full control word is compared
// against a hand-written expected vector.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero, V, N, C, MemReady;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Retire, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;

  int n_checks = 0;
  int n_errors = 0;

  mc_controller #(.ILLEGAL_HALT(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .V(V), .N(N), .C(C), .MemReady(MemReady),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Retire(Retire), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  logic [19:0] obs;
  assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                ALUSrcB, ImmSrc, ALUControl, Retire, Illegal};

  // Control word: pcw adr mw irw rw | rs sa sb | imm | alu | ret ill
  function automatic logic [19:0] mk(input logic pcw, adr, mw, irw, rw,
                                     input logic [1:0] rs, sa, sb,
                                     input logic [2:0] imm, input logic [3:0] alu,
                                     input logic ret, ill);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ret, ill};
  endfunction

  function automatic logic [19:0] w_fetch(input logic rdy, input logic [2:0] imm);
    return mk(rdy, 1'b0, 1'b0, rdy, 1'b0, 2'b10, 2'b00, 2'b10, imm, 4'b0000, 1'b0, 1'b0);
  endfunction

  function automatic logic [19:0] w_decode(input logic [2:0] imm);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, imm, 4'b0000, 1'b0, 1'b0);
  endfunction

  function automatic logic [19:0] w_aluwb(input logic [2:0] imm);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, imm, 4'b0000, 1'b1, 1'b0);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%05h expected=%05h", tag, got, exp);
    end
  endtask

  // Inputs are already set at the falling edge; compare, then move to the next one
  task automatic cyc(input string tag, input logic [19:0] exp);
    #1;
    check(tag, 32'(obs), 32'(exp));
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o; funct3 = f3; funct7b5 = f7;
  endtask

  initial begin
    reset = 1'b1; MemReady = 1'b1; Zero = 1'b0; V = 1'b0; N = 1'b0; C = 1'b0;
    set_instr(7'b0010011, 3'b000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    // In FETCH with MemReady=1, but reset masks all enables
    cyc("reset_masks", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000,
                          4'b0000, 1'b0, 1'b0));
    reset = 1'b0;

    // addi x1,x0,5
    cyc("addi_fetch",  w_fetch(1'b1, 3'b000));
    cyc("addi_decode", w_decode(3'b000));
    cyc("addi_execi",  mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000,
                          4'b0000, 1'b0, 1'b0));
    cyc("addi_aluwb",  w_aluwb(3'b000));

    // sub then sra
    set_instr(7'b0110011, 3'b000, 1'b1);
    cyc("sub_fetch",  w_fetch(1'b1, 3'b000));
    cyc("sub_decode", w_decode(3'b000));
    cyc("sub_execr",  mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b000,
                         4'b0001, 1'b0, 1'b0));
    cyc("sub_aluwb",  w_aluwb(3'b000));
    set_instr(7'b0110011, 3'b101, 1'b1);
    cyc("sra_fetch",  w_fetch(1'b1, 3'b000));
    cyc("sra_decode", w_decode(3'b000));
    cyc("sra_execr",  mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b000,
                         4'b0111, 1'b0, 1'b0));
    cyc("sra_aluwb",  w_aluwb(3'b000));

    // lw with fetch and read stalls: 10 cycles
    set_instr(7'b0000011, 3'b010, 1'b0);
    MemReady = 1'b0;
    cyc("lw_fetch_wait0", w_fetch(1'b0, 3'b000));
    cyc("lw_fetch_wait1", w_fetch(1'b0, 3'b000));
    MemReady = 1'b1;
    cyc("lw_fetch_rdy",   w_fetch(1'b1, 3'b000));
    cyc("lw_decode",      w_decode(3'b000));
    cyc("lw_memadr",      mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000,
                             4'b0000, 1'b0, 1'b0));
    MemReady = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc("lw_memread_wait", mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00,
                                3'b000, 4'b0000, 1'b0, 1'b0));
    MemReady = 1'b1;
    cyc("lw_memread_rdy", mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000,
                             4'b0000, 1'b0, 1'b0));
    cyc("lw_memwb",       mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 3'b000,
                             4'b0000, 1'b1, 1'b0));

    // beq taken, bne not taken, bltu taken
    set_instr(7'b1100011, 3'b000, 1'b0); Zero = 1'b1;
    cyc("beq_fetch",  w_fetch(1'b1, 3'b010));
    cyc("beq_decode", w_decode(3'b010));
    cyc("beq_branch", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b010,
                         4'b0001, 1'b1, 1'b0));
    set_instr(7'b1100011, 3'b001, 1'b0);
    cyc("bne_fetch",  w_fetch(1'b1, 3'b010));
    cyc("bne_decode", w_decode(3'b010));
    cyc("bne_branch", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b010,
                         4'b0001, 1'b1, 1'b0));
    set_instr(7'b1100011, 3'b110, 1'b0); Zero = 1'b0; C = 1'b0;
    cyc("bltu_fetch",  w_fetch(1'b1, 3'b010));
    cyc("bltu_decode", w_decode(3'b010));
    cyc("bltu_branch", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b010,
                          4'b0001, 1'b1, 1'b0));

    // jal
    set_instr(7'b1101111, 3'b000, 1'b0);
    cyc("jal_fetch",  w_fetch(1'b1, 3'b011));
    cyc("jal_decode", w_decode(3'b011));
    cyc("jal_jal",    mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b011,
                         4'b0000, 1'b0, 1'b0));
    cyc("jal_aluwb",  w_aluwb(3'b011));

    // lui
    set_instr(7'b0110111, 3'b000, 1'b0);
    cyc("lui_fetch",  w_fetch(1'b1, 3'b100));
    cyc("lui_decode", w_decode(3'b100));
    cyc("lui_lui",    mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 2'b01, 3'b100,
                         4'b0000, 1'b0, 1'b0));
    cyc("lui_aluwb",  w_aluwb(3'b100));

    // sw with one write stall, completing normally
    set_instr(7'b0100011, 3'b010, 1'b0);
    cyc("sw_fetch",  w_fetch(1'b1, 3'b001));
    cyc("sw_decode", w_decode(3'b001));
    cyc("sw_memadr", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b001,
                        4'b0000, 1'b0, 1'b0));
    MemReady = 1'b0;
    cyc("sw_memwrite_wait", mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b001,
                               4'b0000, 1'b0, 1'b0));
    MemReady = 1'b1;
    cyc("sw_memwrite_rdy",  mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b001,
                               4'b0000, 1'b1, 1'b0));

    // sw aborted by reset while the write is stalled
    cyc("sw2_fetch",  w_fetch(1'b1, 3'b001));
    cyc("sw2_decode", w_decode(3'b001));
    cyc("sw2_memadr", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b001,
                         4'b0000, 1'b0, 1'b0));
    MemReady = 1'b0; reset = 1'b1;
    cyc("sw2_reset_memwrite", mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b001,
                                 4'b0000, 1'b0, 1'b0));
    reset = 1'b0; MemReady = 1'b1;
    cyc("sw2_after_reset_fetch", w_fetch(1'b1, 3'b001));

    // Illegal opcode parks the FSM until reset
    set_instr(7'b1111111, 3'b000, 1'b0);
    cyc("ill_decode", w_decode(3'b000));
    for (int i = 0; i < 20; i++)
      cyc("ill_hold", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000,
                         4'b0000, 1'b0, 1'b1));
    reset = 1'b1;
    cyc("ill_reset_cycle", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000,
                              4'b0000, 1'b0, 1'b1));
    cyc("ill_cleared", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000,
                          4'b0000, 1'b0, 1'b0));
    reset = 1'b0;
    cyc("ill_refetch", w_fetch(1'b1, 3'b000));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
